// File: rtl/ir_pkg.sv
// Shared NEC infrared definitions: frame field offsets, default clock,
// decoder FSM state encoding and the decoded-entry layout.
package ir_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;

    // NEC burst layout {~cmd, cmd, ~addr, addr}, LSB offsets of each byte
    localparam int NEC_ADDR_LSB  = 0;
    localparam int NEC_NADDR_LSB = 8;
    localparam int NEC_CMD_LSB   = 16;
    localparam int NEC_NCMD_LSB  = 24;

    // Decoder FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_PUSH   = 2'd2;
    localparam logic [1:0] ST_REJECT = 2'd3;

    // One queued key event
    typedef struct packed {
        logic       rpt;
        logic [7:0] cmd;
        logic [7:0] addr;
    } ir_entry_t;

    function automatic logic [7:0] nec_addr(input logic [31:0] b);
        return b[NEC_ADDR_LSB +: 8];
    endfunction

    function automatic logic [7:0] nec_cmd(input logic [31:0] b);
        return b[NEC_CMD_LSB +: 8];
    endfunction

    // A frame is good when both inverted bytes match their partners
    function automatic logic nec_frame_ok(input logic [31:0] b);
        return (b[NEC_NADDR_LSB +: 8] == ~b[NEC_ADDR_LSB +: 8]) &&
               (b[NEC_NCMD_LSB +: 8] == ~b[NEC_CMD_LSB +: 8]);
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Show-ahead FIFO with modulo-DEPTH pointers and a separate occupancy
// counter for full/empty. A push while full is dropped unless a pop
// happens on the same edge. The head is presented as zero when empty.
module ir_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, not reset: empty masks stale contents
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ir_decode.sv
// NEC frame decoder: validates bursts from the receiver, tags key-hold
// repeats, queues decoded entries and counts rejected frames.
module ir_decode
    import ir_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int HOLD_MS = 120,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] burst,
    input  logic        ready,
    input  logic        pop,
    output logic [7:0]  addr,
    output logic [7:0]  cmd,
    output logic        rpt,
    output logic        valid,
    output logic        held,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        overflow
);

    localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
    localparam int HOLD_W   = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    logic [1:0]        state;
    logic [31:0]       burst_p0;
    logic [15:0]       code_p0;
    logic [15:0]       last_code;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        err_cnt_q;
    logic              ovf_q;
    logic              push;
    logic              pop_ok;
    logic              fifo_full;
    logic              fifo_empty;
    ir_entry_t         wr_entry;
    ir_entry_t         rd_entry;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign code_p0   = {nec_cmd(burst_p0), nec_addr(burst_p0)};
    assign push      = (state == ST_PUSH);
    assign held      = (hold_cnt != '0);
    assign err       = (state == ST_REJECT);
    assign valid     = !fifo_empty;
    assign pop_ok    = pop && valid;
    assign addr      = rd_entry.addr;
    assign cmd       = rd_entry.cmd;
    assign rpt       = rd_entry.rpt;
    assign err_count = err_cnt_q;
    assign overflow  = ovf_q;

    // Entry written on push; repeat means same code while still held
    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = code_p0[7:0];
        wr_entry.cmd  = code_p0[15:8];
        wr_entry.rpt  = held && (code_p0 == last_code);
    end

    // Frame sequencing: capture, validate, then push or reject
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (ready) state <= ST_CHECK;
                ST_CHECK: state <= nec_frame_ok(burst_p0) ? ST_PUSH : ST_REJECT;
                ST_PUSH:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Capture stage: burst latched only when the FSM can accept it
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && ready) burst_p0 <= burst;
    end

    // Key-hold window and the code it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            last_code <= '0;
        end else if (push) begin
            hold_cnt  <= HOLD_LOAD;
            last_code <= code_p0;
        end else if (held) begin
            hold_cnt  <= hold_cnt - HOLD_W'(1);
        end
    end

    // Error counter and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (state == ST_REJECT) err_cnt_q <= sat_inc8(err_cnt_q);
            if (push && fifo_full && !pop_ok) ovf_q <= 1'b1;
        end
    end

    ir_fifo #(
        .WIDTH($bits(ir_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(wr_entry),
        .rdata(rd_entry),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_ir_decode.sv
// Bench for ir_decode: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_ir_decode;

    localparam int CLK_HZ   = 10_000;
    localparam int HOLD_MS  = 120;
    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
    localparam int CYC_MS   = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] burst = '0;
    logic        ready = 1'b0;
    logic        pop = 1'b0;
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic        rpt;
    logic        valid;
    logic        held;
    logic        err;
    logic [7:0]  err_count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ir_decode #(.CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .burst(burst), .ready(ready), .pop(pop),
        .addr(addr), .cmd(cmd), .rpt(rpt), .valid(valid), .held(held),
        .err(err), .err_count(err_count), .overflow(overflow)
    );

    // Behavioural model: a frame in flight, a queue of entries, a hold
    // window expressed as the edge it was started on, plain counters.
    logic [16:0] mq[$];
    int          m_stage = -1;
    logic [31:0] m_burst = '0;
    longint      edge_n = 0;
    longint      m_load_edge = 0;
    bit          m_loaded = 0;
    logic [15:0] m_last = '0;
    int          m_errc = 0;
    bit          m_ovf = 0;
    bit          m_live = 0;

    function automatic bit good(input logic [31:0] b);
        return (b[15:8] == ~b[7:0]) && (b[31:24] == ~b[23:16]);
    endfunction

    function automatic bit m_held();
        return m_loaded && ((edge_n - m_load_edge) < longint'(HOLD_CYC - 1));
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    always @(posedge clk) begin
        bit          h;
        bit          pop_eff;
        logic [15:0] code;
        h = m_held();
        edge_n++;
        if (rst) begin
            mq.delete();
            m_stage  = -1;
            m_loaded = 0;
            m_last   = '0;
            m_errc   = 0;
            m_ovf    = 0;
            m_live   = 1;
        end else begin
            pop_eff = pop && (mq.size() > 0);
            if (pop_eff) void'(mq.pop_front());
            if (m_stage == 1) begin
                if (good(m_burst)) begin
                    code = {m_burst[23:16], m_burst[7:0]};
                    if (mq.size() < DEPTH) mq.push_back({h && (code == m_last), code});
                    else m_ovf = 1;
                    m_loaded    = 1;
                    m_load_edge = edge_n;
                    m_last      = code;
                end else if (m_errc < 255) begin
                    m_errc++;
                end
                m_stage = -1;
            end else if (m_stage == 0) begin
                m_stage = 1;
            end else if (ready) begin
                m_stage = 0;
                m_burst = burst;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [28:0] got;
        logic [28:0] exp;
        logic [16:0] head;
        if (m_live) begin
            head = (mq.size() > 0) ? mq[0] : 17'd0;
            exp  = {mq.size() > 0, head[7:0], head[15:8], head[16], m_held(),
                    (m_stage == 1) && !good(m_burst), 8'(m_errc), m_ovf};
            got  = {valid, addr, cmd, rpt, held, err, err_count, overflow};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL model cycle %0d: got {v,a,c,r,h,e,ec,o}=%h required %h", edge_n, got, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] b);
        burst = b;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic pop1();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        check("reset_outputs", {valid, addr, cmd, rpt, held, err, err_count, overflow}, 0);

        // Basic frame and latency
        send(32'h27D8EF10);
        tick(1);
        check("latency_not_early", valid, 0);
        tick(1);
        check("basic_entry", {valid, addr, cmd, rpt, held}, {1'b1, 8'h10, 8'hD8, 1'b0, 1'b1});
        pop1();
        check("basic_popped", valid, 0);

        // Bad inverted address
        send(32'h27D8EE10);
        tick(1);
        check("bad_err_pulse", err, 1);
        tick(1);
        check("bad_after", {err, err_count, valid, held}, {1'b0, 8'd1, 1'b0, 1'b1});

        // Key-hold repeat, then expiry
        reset_pulse();
        send(32'h27D8EF10);
        tick(2);
        check("hold_first_rpt", {valid, rpt}, {1'b1, 1'b0});
        pop1();
        tick(50 * CYC_MS - 4);
        send(32'h27D8EF10);
        tick(2);
        check("hold_second_rpt", {valid, rpt}, {1'b1, 1'b1});
        pop1();
        tick(200 * CYC_MS - 4);
        check("hold_dropped", held, 0);
        send(32'h27D8EF10);
        tick(2);
        check("hold_third_rpt", {valid, rpt, held}, {1'b1, 1'b0, 1'b1});
        pop1();

        // Overflow: five frames, no pop
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            send(mk(8'(i + 1), 8'(8'h30 + i)));
            tick(2);
        end
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", {valid, addr, cmd}, {1'b1, 8'(i + 1), 8'(8'h30 + i)});
            pop1();
        end
        check("ovf_fifth_absent", valid, 0);

        // Pop while empty, then push+pop at full
        pop1();
        check("empty_pop", {valid, overflow, err_count}, {1'b1 == 1'b0, 1'b1, 8'd0});
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            send(mk(8'(i + 1), 8'h55));
            tick(2);
        end
        send(mk(8'd5, 8'h55));
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        check("full_pushpop_head", {valid, addr, overflow}, {1'b1, 8'd2, 1'b0});
        for (int i = 0; i < 4; i++) begin
            check("full_pushpop_drain", {valid, addr}, {1'b1, 8'(i + 2)});
            pop1();
        end
        check("full_pushpop_count", valid, 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send(32'h27D8EE10);
            tick(2);
        end
        check("err_saturate", err_count, 8'd255);

        // Reset mid-frame discards it
        send(32'h27D8EF10);
        reset_pulse();
        tick(3);
        check("reset_midframe", {valid, addr, cmd, rpt, held, err, err_count, overflow}, 0);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            int sel;
            int pop_w;
            sel   = int'($urandom_range(0, 3));
            pop_w = (i < 3000) ? 2 : 8;
            if (sel == 0) burst = $urandom;
            else burst = mk(8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)));
            ready = ($urandom_range(0, 3) == 0);
            pop   = ($urandom_range(0, pop_w) == 0);
            rst   = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        rst   = 1'b0;
        ready = 1'b0;
        pop   = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
